// File: rtl/sp_ram_bist_pkg.sv
// Shared definitions for the single-port RAM march BIST: FSM state codes,
// sweep direction and the data pattern generator.
package sp_ram_bist_pkg;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_WR0  = 3'd1;
  localparam state_t S_RD0  = 3'd2;
  localparam state_t S_WR1  = 3'd3;
  localparam state_t S_RD1  = 3'd4;
  localparam state_t S_FIN  = 3'd5;

  // Address sweep direction of a march pass
  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  // Widest data word the pattern helper supports; callers truncate.
  localparam int PAT_W = 64;

  // pat(w) = seed ^ w, optionally inverted for the second write/read pair.
  function automatic logic [PAT_W-1:0] bist_pattern(
    input logic [PAT_W-1:0] seed,
    input logic [PAT_W-1:0] idx,
    input logic             inv
  );
    logic [PAT_W-1:0] p;
    p = seed ^ idx;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/sp_ram_bist_cmp.sv
// Readback checker: registers the expected word and address of each read,
// compares against RAM data one cycle later, keeps a saturating mismatch
// count and remembers the address of the first mismatch of a run.
module sp_ram_bist_cmp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  clear,
  input  logic                  flush,
  input  logic                  vld_p0,
  input  logic [DATA_WIDTH-1:0] exp_p0,
  input  logic [ADDR_WIDTH-1:0] addr_p0,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  mismatch
);

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] exp_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;

  // Counter never wraps back to zero, so zero also means "no failure yet".
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // p0 -> p1: read issued this cycle, data returns next cycle
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) vld_p1 <= 1'b0;
    else       vld_p1 <= vld_p0 && !flush && !clear;
  end

  // Expected word and address travel with vld_p1 and need no reset
  always_ff @(posedge clk) begin
    exp_p1  <= exp_p0;
    addr_p1 <= addr_p0;
  end

  // p1: compare returned data, aborted runs discard the pending compare
  assign mismatch = vld_p1 && !flush && (rdata != exp_p1);

  // Error counter and first-fail capture, cleared on an accepted start
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      err_cnt   <= '0;
      fail_addr <= '0;
    end else if (clear) begin
      err_cnt   <= '0;
      fail_addr <= '0;
    end else if (mismatch) begin
      err_cnt <= sat_inc(err_cnt);
      if (err_cnt == '0) fail_addr <= addr_p1;
    end
  end

endmodule

// File: rtl/sp_ram_bist.sv
// March BIST initiator for the single-port RAM: WR0 (up, pat), RD0 (up),
// WR1 (down, ~pat), RD1 (down), one access per cycle, then a FIN cycle
// that drains the last compare before reporting done/pass.
module sp_ram_bist
  import sp_ram_bist_pkg::*;
#(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [DATA_WIDTH-1:0]   seed_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [ERR_CNT_W-1:0]    err_cnt_o,
  output logic [ADDR_WIDTH-1:0]   fail_addr_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic                    ram_bypass_en_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int                WORD_W   = ADDR_WIDTH - 2;
  localparam int                N_WORDS  = RAM_SIZE / 4;
  localparam logic [WORD_W-1:0] LAST_IDX = WORD_W'(N_WORDS - 1);

  state_t                state, state_n;
  logic [WORD_W-1:0]     idx, idx_n, step_idx;
  logic [DATA_WIDTH-1:0] seed_q, seed_n;
  dir_e                  dir;
  logic                  end_pass;
  logic                  start_acc, fin_done;
  logic                  acc_n, wr_n;
  logic [DATA_WIDTH-1:0] wpat_n, exp_rd;
  logic                  rd_issue, mismatch;

  assign dir      = (state == S_WR1 || state == S_RD1) ? DIR_DN : DIR_UP;
  assign step_idx = (dir == DIR_UP) ? idx + 1'b1 : idx - 1'b1;
  assign end_pass = (dir == DIR_UP) ? (idx == LAST_IDX) : (idx == '0);

  // Next-state and word-index sequencing; abort wins over any pass step
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    start_acc = 1'b0;
    fin_done  = 1'b0;
    if (state != S_IDLE && abort_i) begin
      state_n = S_IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          state_n   = S_WR0;
          idx_n     = '0;
          start_acc = 1'b1;
        end
        S_WR0: if (end_pass) begin
          state_n = S_RD0;
          idx_n   = '0;
        end else idx_n = step_idx;
        S_RD0: if (end_pass) begin
          state_n = S_WR1;
          idx_n   = LAST_IDX;
        end else idx_n = step_idx;
        S_WR1: if (end_pass) begin
          state_n = S_RD1;
          idx_n   = LAST_IDX;
        end else idx_n = step_idx;
        S_RD1: if (end_pass) begin
          state_n = S_FIN;
          idx_n   = '0;
        end else idx_n = step_idx;
        S_FIN: begin
          state_n  = S_IDLE;
          fin_done = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // The first write must already use the seed being captured this edge
  assign seed_n = start_acc ? seed_i : seed_q;
  assign acc_n  = (state_n == S_WR0) || (state_n == S_RD0) ||
                  (state_n == S_WR1) || (state_n == S_RD1);
  assign wr_n   = (state_n == S_WR0) || (state_n == S_WR1);
  assign wpat_n = DATA_WIDTH'(bist_pattern(PAT_W'(seed_n), PAT_W'(idx_n),
                                           state_n == S_WR1));

  // Seed is plain data, captured on an accepted start
  always_ff @(posedge clk) begin
    if (start_acc) seed_q <= seed_i;
  end

  // FSM, status and RAM port registers
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      idx         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      ram_en_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_be_o    <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      busy_o      <= (state_n != S_IDLE);
      done_o      <= fin_done;
      if (start_acc)     pass_o <= 1'b0;
      else if (fin_done) pass_o <= (err_cnt_o == '0) && !mismatch;
      ram_en_o    <= acc_n;
      ram_we_o    <= wr_n;
      ram_addr_o  <= acc_n ? {idx_n, 2'b00} : '0;
      ram_wdata_o <= wr_n ? wpat_n : '0;
      ram_be_o    <= acc_n ? '1 : '0;
    end
  end

  assign ram_bypass_en_o = 1'b0;

  // A read on the port this cycle expects pat or ~pat of the current word
  assign rd_issue = (state == S_RD0) || (state == S_RD1);
  assign exp_rd   = DATA_WIDTH'(bist_pattern(PAT_W'(seed_q), PAT_W'(idx),
                                             state == S_RD1));

  sp_ram_bist_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ERR_CNT_W  (ERR_CNT_W)
  ) u_cmp (
    .clk       (clk),
    .rst_i     (rst_i),
    .clear     (start_acc),
    .flush     (abort_i),
    .vld_p0    (rd_issue),
    .exp_p0    (exp_rd),
    .addr_p0   (ram_addr_o),
    .rdata     (ram_rdata_i),
    .err_cnt   (err_cnt_o),
    .fail_addr (fail_addr_o),
    .mismatch  (mismatch)
  );

endmodule

// File: tb/tb_sp_ram_bist.sv
// Directed bench for sp_ram_bist with a 16-word, 1-cycle-latency RAM model
// that can inject read faults.
module tb_sp_ram_bist;

  localparam int RAM_SIZE   = 64;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 32;
  localparam int ERR_CNT_W  = 4;
  localparam int N          = 16;

  logic                    clk = 1'b0;
  logic                    rst_i;
  logic                    start_i;
  logic                    abort_i;
  logic [DATA_WIDTH-1:0]   seed_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    pass_o;
  logic [ERR_CNT_W-1:0]    err_cnt_o;
  logic [ADDR_WIDTH-1:0]   fail_addr_o;
  logic                    ram_en_o;
  logic [ADDR_WIDTH-1:0]   ram_addr_o;
  logic [DATA_WIDTH-1:0]   ram_wdata_o;
  logic                    ram_we_o;
  logic [DATA_WIDTH/8-1:0] ram_be_o;
  logic                    ram_bypass_en_o;
  logic [DATA_WIDTH-1:0]   ram_rdata_i = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fault_mode = 0;
  logic [31:0] mem [0:N-1];

  always #5 clk = ~clk;

  sp_ram_bist #(
    .RAM_SIZE   (RAM_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .seed_i          (seed_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .pass_o          (pass_o),
    .err_cnt_o       (err_cnt_o),
    .fail_addr_o     (fail_addr_o),
    .ram_en_o        (ram_en_o),
    .ram_addr_o      (ram_addr_o),
    .ram_wdata_o     (ram_wdata_o),
    .ram_we_o        (ram_we_o),
    .ram_be_o        (ram_be_o),
    .ram_bypass_en_o (ram_bypass_en_o),
    .ram_rdata_i     (ram_rdata_i)
  );

  // 1: bit 3 stuck at 1 on word 5; 2: reads return 0; 3: bit 3 stuck at 1 on words 2 and 5
  function automatic logic [31:0] fault(input logic [31:0] d, input int w);
    case (fault_mode)
      1:       return (w == 5) ? (d | 32'h8) : d;
      2:       return 32'h0;
      3:       return (w == 2 || w == 5) ? (d | 32'h8) : d;
      default: return d;
    endcase
  endfunction

  // RAM model: write or registered read, data valid the following cycle
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o[5:2]] <= ram_wdata_o;
      else          ram_rdata_i <= fault(mem[ram_addr_o[5:2]], int'(ram_addr_o[5:2]));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_run(input logic [31:0] seed);
    seed_i  = seed;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cyc     = 1;
  endtask

  task automatic run_to_done(output int at);
    while (done_o !== 1'b1 && cyc < 200) step();
    at = cyc;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy_o, done_o, pass_o, err_cnt_o, fail_addr_o, ram_en_o,
                ram_addr_o, ram_wdata_o, ram_we_o, ram_be_o, ram_bypass_en_o});
  endfunction

  initial begin
    int          at;
    int          k, ps, w;
    logic        e_we;
    logic [5:0]  e_addr;
    logic [31:0] e_wd, p;
    logic        saw_done;

    rst_i   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    seed_i  = '0;
    #2 rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 64'h0);
    #2 rst_i = 1'b0;
    step();

    // Clean run: exact access sequence over all four passes
    start_run(32'hA5A50000);
    for (int c = 1; c <= 4 * N; c++) begin
      k  = c - 1;
      ps = k / N;
      w  = (ps < 2) ? (k % N) : (N - 1 - (k % N));
      p  = 32'hA5A50000 ^ 32'(w);
      e_we   = (ps == 0 || ps == 2);
      e_addr = 6'(w * 4);
      e_wd   = !e_we ? 32'h0 : (ps == 0 ? p : ~p);
      chk("access_seq",
          64'({busy_o, ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_bypass_en_o,
               (ram_we_o ? ram_wdata_o : 32'h0)}),
          64'({1'b1, 1'b1, e_we, e_addr, 4'hF, 1'b0, e_wd}));
      step();
    end
    chk("fin_cycle", 64'(cyc), 64'd65);
    chk("fin_busy_en_done", 64'({busy_o, ram_en_o, done_o}), 64'(3'b100));
    step();
    chk("done_busy_pass", 64'({done_o, busy_o, pass_o}), 64'(3'b101));
    chk("clean_err_cnt", 64'(err_cnt_o), 64'd0);
    step();
    chk("done_one_cycle", 64'(done_o), 64'd0);

    // Stuck-at-1 on bit 3 of word 5: only the RD0 read of word 5 fails
    fault_mode = 1;
    start_run(32'hA5A50000);
    run_to_done(at);
    chk("sa1_done_cycle", 64'(at), 64'd66);
    chk("sa1_err_cnt", 64'(err_cnt_o), 64'd1);
    chk("sa1_fail_addr", 64'(fail_addr_o), 64'h14);
    chk("sa1_pass", 64'(pass_o), 64'd0);

    // Two faulty words: first failing address is kept, not the last
    fault_mode = 3;
    start_run(32'hA5A50000);
    run_to_done(at);
    chk("two_err_cnt", 64'(err_cnt_o), 64'd2);
    chk("two_fail_addr", 64'(fail_addr_o), 64'h08);

    // Every read returns 0: 32 mismatches saturate a 4-bit counter
    fault_mode = 2;
    start_run(32'hA5A50000);
    run_to_done(at);
    chk("zero_err_sat", 64'(err_cnt_o), 64'd15);
    chk("zero_fail_addr", 64'(fail_addr_o), 64'h00);
    chk("zero_pass", 64'(pass_o), 64'd0);

    // Start pulse mid-run is ignored (seed and timing unchanged)
    fault_mode = 0;
    start_run(32'hA5A50000);
    while (cyc < 10) step();
    seed_i  = 32'h12345678;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_to_done(at);
    chk("restart_done_cycle", 64'(at), 64'd66);
    chk("restart_pass", 64'(pass_o), 64'd1);
    chk("restart_err_cleared", 64'(err_cnt_o), 64'd0);

    // Abort at cycle 20
    start_run(32'hA5A50000);
    while (cyc < 20) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_busy_en", 64'({busy_o, ram_en_o}), 64'd0);
    saw_done = 1'b0;
    while (cyc < 80) begin
      step();
      if (done_o) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    chk("abort_pass", 64'(pass_o), 64'd0);

    // Abort alone in IDLE does nothing; abort with start starts a run
    abort_i = 1'b1;
    step();
    chk("idle_abort_busy", 64'(busy_o), 64'd0);
    start_i = 1'b1;
    seed_i  = 32'h0F0F0F0F;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    cyc     = 1;
    chk("abort_start_busy", 64'(busy_o), 64'd1);
    run_to_done(at);
    chk("abort_start_done", 64'(at), 64'd66);
    chk("abort_start_pass", 64'(pass_o), 64'd1);

    // Reset mid-RD0 clears outputs without waiting for a clock edge
    start_run(32'hA5A50000);
    while (cyc < 20) step();
    #2 rst_i = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 64'h0);
    @(posedge clk);
    #3 rst_i = 1'b0;
    step();
    start_run(32'hA5A50000);
    run_to_done(at);
    chk("post_reset_done", 64'(at), 64'd66);
    chk("post_reset_pass_err", 64'({pass_o, err_cnt_o}), 64'({1'b1, 4'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
